// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO controller: window base, register offsets,
// status bit positions and the TX sequencer state encoding.
package mmio_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h8000_0000;

  localparam logic [7:0] OFS_STATUS = 8'h00;
  localparam logic [7:0] OFS_RX     = 8'h04;
  localparam logic [7:0] OFS_TX     = 8'h08;
  localparam logic [7:0] OFS_CYC    = 8'h10;
  localparam logic [7:0] OFS_INST   = 8'h14;
  localparam logic [7:0] OFS_CRST   = 8'h18;

  localparam int STAT_TX_FREE  = 0;
  localparam int STAT_RX_AVAIL = 1;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_t;

endpackage

// File: rtl/mmio_rx_fifo.sv
// Synchronous RX byte FIFO; pointers carry one extra wrap bit so that
// full and empty are distinguished without a separate count.
module mmio_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset: an entry is only visible once its write pointer passed it.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mmio_uart_ctrl.sv
// MMIO window beside dmem: UART TX sequencer, RX FIFO, cycle/instret counters,
// and a registered load-data path with dmem-equivalent 1-cycle latency.
module mmio_uart_ctrl
  import mmio_pkg::*;
#(
  parameter int          RX_DEPTH  = 8,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  input  logic        inst_retired,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready
);

  tx_state_t   state, state_next;
  logic [31:0] cyc_cnt;
  logic [31:0] inst_cnt;
  logic [7:0]  ofs;
  logic        in_win, ld, st;
  logic        fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [7:0]  fifo_head;
  logic        tx_load, cnt_clr;
  logic        unused_bits;

  assign unused_bits = ^{req_wdata[31:8], req_addr[1:0]};

  assign ofs    = {req_addr[7:2], 2'b00};
  assign in_win = req_valid && (req_addr[31:8] == MMIO_BASE[31:8]);
  assign ld     = in_win && !req_we;
  assign st     = in_win && req_we;

  assign fifo_push     = uart_rx_valid && !fifo_full;
  assign fifo_pop      = ld && (ofs == OFS_RX) && !fifo_empty;
  assign uart_rx_ready = !fifo_full;

  assign tx_load = st && (ofs == OFS_TX) && (state == TX_IDLE);
  assign cnt_clr = st && (ofs == OFS_CRST);

  mmio_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (uart_rx_data),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_next    = state;
    uart_tx_valid = 1'b0;
    case (state)
      TX_IDLE: if (tx_load) state_next = TX_SEND;
      TX_SEND: begin
        uart_tx_valid = 1'b1;
        if (uart_tx_ready) state_next = TX_IDLE;
      end
      default: state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= TX_IDLE;
      uart_tx_data <= '0;
    end else begin
      state <= state_next;
      if (tx_load) uart_tx_data <= req_wdata[7:0];
    end
  end

  // Counter clear takes priority over the increment in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst || cnt_clr) begin
      cyc_cnt  <= '0;
      inst_cnt <= '0;
    end else begin
      cyc_cnt  <= cyc_cnt + 32'd1;
      inst_cnt <= inst_cnt + 32'(inst_retired);
    end
  end

  // Load data samples pre-update state, so a read sees values before this edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata <= '0;
    end else if (ld) begin
      case (ofs)
        OFS_STATUS: begin
          rdata                <= '0;
          rdata[STAT_TX_FREE]  <= (state == TX_IDLE);
          rdata[STAT_RX_AVAIL] <= !fifo_empty;
        end
        OFS_RX:   rdata <= fifo_empty ? 32'd0 : {24'd0, fifo_head};
        OFS_CYC:  rdata <= cyc_cnt;
        OFS_INST: rdata <= inst_cnt;
        default:  rdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Directed bench for mmio_uart_ctrl: inputs change and outputs are sampled on
// the falling edge, so every posedge sees stable stimulus.
module tb_mmio_uart_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rdata;
  logic        inst_retired;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] BASE = 32'h8000_0000;

  always #5 clk = ~clk;

  mmio_uart_ctrl #(.RX_DEPTH(8), .MMIO_BASE(BASE)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rdata         (rdata),
    .inst_retired  (inst_retired),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_ready (uart_rx_ready),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; issues a one-cycle load and returns at the next negedge.
  task automatic do_load(input logic [7:0] ofs);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = BASE | 32'(ofs);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_store(input logic [7:0] ofs, input logic [31:0] data);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = BASE | 32'(ofs);
    req_wdata = data;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    uart_rx_valid = 1'b1;
    uart_rx_data  = b;
    @(negedge clk);
    uart_rx_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    inst_retired = 1'b0; uart_rx_data = '0; uart_rx_valid = 1'b0; uart_tx_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rdata", rdata, 32'h0);
    check("rst_tx_valid", 32'(uart_tx_valid), 32'h0);
    check("rst_tx_data", 32'(uart_tx_data), 32'h0);
    check("rst_rx_ready", 32'(uart_rx_ready), 32'h1);
    rst = 1'b1;
    @(negedge clk);

    do_load(8'h00);
    check("status_idle", rdata, 32'h1);

    // RX two bytes, in-order pop
    push_byte(8'h41);
    push_byte(8'h42);
    do_load(8'h00);
    check("status_rx_avail", rdata, 32'h3);
    do_load(8'h04);
    check("rx_pop0", rdata, 32'h41);
    do_load(8'h04);
    check("rx_pop1", rdata, 32'h42);
    do_load(8'h00);
    check("status_drained", rdata, 32'h1);
    do_load(8'h04);
    check("rx_empty_read", rdata, 32'h0);

    // Fill the FIFO; a ninth byte waits until a pop frees a slot
    for (int i = 1; i <= 8; i++) push_byte(8'(8'h10 + i));
    check("rx_full_ready", 32'(uart_rx_ready), 32'h0);
    uart_rx_valid = 1'b1;
    uart_rx_data  = 8'h99;
    @(negedge clk);
    check("rx_full_hold", 32'(uart_rx_ready), 32'h0);
    do_load(8'h04);
    check("rx_pop_full", rdata, 32'h11);
    check("rx_ready_after_pop", 32'(uart_rx_ready), 32'h1);
    @(negedge clk);
    uart_rx_valid = 1'b0;
    check("rx_ninth_accepted", 32'(uart_rx_ready), 32'h0);
    for (int i = 2; i <= 8; i++) begin
      do_load(8'h04);
      check("rx_drain", rdata, 32'(8'h10 + i));
    end
    do_load(8'h04);
    check("rx_ninth_byte", rdata, 32'h99);
    do_load(8'h00);
    check("status_after_drain", rdata, 32'h1);

    // TX held while the transmitter stalls; a second store is dropped
    do_store(8'h08, 32'hFFFF_FF55);
    for (int i = 0; i < 5; i++) begin
      check("tx_valid_held", 32'(uart_tx_valid), 32'h1);
      check("tx_data_held", 32'(uart_tx_data), 32'h55);
      @(negedge clk);
    end
    do_store(8'h08, 32'h0000_00AA);
    check("tx_drop_busy", 32'(uart_tx_data), 32'h55);
    do_load(8'h00);
    check("status_busy", rdata, 32'h0);
    uart_tx_ready = 1'b1;
    @(negedge clk);
    uart_tx_ready = 1'b0;
    check("tx_valid_done", 32'(uart_tx_valid), 32'h0);
    do_load(8'h00);
    check("status_tx_free", rdata, 32'h1);

    // Store in the handshake cycle is dropped
    do_store(8'h08, 32'h66);
    uart_tx_ready = 1'b1;
    do_store(8'h08, 32'h77);
    uart_tx_ready = 1'b0;
    check("tx_hs_idle", 32'(uart_tx_valid), 32'h0);
    check("tx_hs_data", 32'(uart_tx_data), 32'h66);

    // Stores to read-only registers and out-of-window requests have no effect
    do_store(8'h04, 32'h12);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8000_0108; req_wdata = 32'h5A;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    check("outside_window", 32'(uart_tx_valid), 32'h0);
    do_load(8'h00);
    check("status_ro_store", rdata, 32'h1);
    do_load(8'h0C);
    check("unmapped_read", rdata, 32'h0);

    // Counters: clear, then 100 cycles with 37 retirements
    do_store(8'h18, 32'h0);
    for (int i = 0; i < 100; i++) begin
      inst_retired = (i < 37);
      @(negedge clk);
    end
    inst_retired = 1'b0;
    do_load(8'h10);
    check("cyc_count", rdata, 32'd100);
    do_load(8'h14);
    check("inst_count", rdata, 32'd37);
    inst_retired = 1'b1;
    do_store(8'h18, 32'h0);
    inst_retired = 1'b0;
    do_load(8'h10);
    check("cyc_cleared", rdata, 32'd0);
    do_load(8'h14);
    check("inst_cleared", rdata, 32'd0);

    // Cycle counter wrap
    force dut.cyc_cnt = 32'hFFFF_FFFF;
    #1 release dut.cyc_cnt;
    do_load(8'h10);
    check("cyc_preset", rdata, 32'hFFFF_FFFF);
    do_load(8'h10);
    check("cyc_wrap", rdata, 32'h0);

    // Reset mid-SEND with buffered RX bytes
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    do_store(8'h08, 32'h33);
    check("pre_rst_tx_valid", 32'(uart_tx_valid), 32'h1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midrst_tx_valid", 32'(uart_tx_valid), 32'h0);
    check("midrst_tx_data", 32'(uart_tx_data), 32'h0);
    check("midrst_rdata", rdata, 32'h0);
    do_load(8'h00);
    check("midrst_status", rdata, 32'h1);
    do_load(8'h04);
    check("midrst_rx_empty", rdata, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
